// File: rtl/blob_pkg.sv
// blob_pkg: shared defaults, state encoding, result record and error bit positions
package blob_pkg;
  localparam int DEF_IMG_COL     = 800;
  localparam int DEF_IMG_ROW     = 600;
  localparam int DEF_CAT_WAIT    = 2048;
  localparam int DEF_TIMEOUT_CYC = 1048576;
  localparam int ERR_UNDERRUN    = 0;
  localparam int ERR_TIMEOUT     = 1;
  typedef enum logic [2:0] {IDLE, ARM, STREAM, WAIT_RES, CAT, HOLD, RELEASE} seq_state_e;
  typedef struct packed {
    logic [7:0] count;
    logic [7:0] bigger;
    logic [7:0] smaller;
  } blob_result_t;
endpackage

// File: rtl/blob_raster_counter.sv
// blob_raster_counter: col/row position of the pixel being streamed, with frame-end and border flags
module blob_raster_counter import blob_pkg::*; #(
  parameter int IMG_COL = DEF_IMG_COL,
  parameter int IMG_ROW = DEF_IMG_ROW
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_last_pix,
  output logic o_border
);
  logic [9:0] r_col, r_row;
  logic       w_last_col, w_last_row;
  assign w_last_col = r_col == 10'(IMG_COL - 1);
  assign w_last_row = r_row == 10'(IMG_ROW - 1);
  assign o_last_pix = w_last_col & w_last_row;
  assign o_border   = (r_col == '0) | w_last_col | (r_row == '0) | w_last_row;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      r_col <= w_last_col ? '0 : r_col + 10'd1;
      r_row <= w_last_col ? (w_last_row ? '0 : r_row + 10'd1) : r_row;
    end
endmodule

// File: rtl/blob_scan_sequencer.sv
// blob_scan_sequencer: streams one binarized frame into the blob counter per start and latches its results.
// Define SEQ_BORDER_MASK_EN to force the foreground bit to 0 on the frame border.
module blob_scan_sequencer import blob_pkg::*; #(
  parameter int IMG_COL     = DEF_IMG_COL,
  parameter int IMG_ROW     = DEF_IMG_ROW,
  parameter int CAT_WAIT    = DEF_CAT_WAIT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic [7:0] i_threshold,
  input  logic       i_pix_valid,
  input  logic [7:0] i_pix_luma,
  output logic       o_pix_ready,
  output logic       o_blob_valid,
  output logic       o_blob_seq,
  output logic       o_blob_switch,
  input  logic       i_blob_done,
  input  logic [7:0] i_blob_count,
  input  logic [7:0] i_blob_bigger,
  input  logic [7:0] i_blob_smaller,
  output logic [7:0] o_count,
  output logic [7:0] o_bigger,
  output logic [7:0] o_smaller,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_err
);
`ifdef SEQ_BORDER_MASK_EN
  localparam logic MASK_BORDER = 1'b1;
`else
  localparam logic MASK_BORDER = 1'b0;
`endif
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYC - 1);
  localparam logic [19:0] CAT_LAST = 20'(CAT_WAIT - 1);
  logic [2:0]   r_state, w_next;
  logic [19:0]  r_wait;
  logic [1:0]   r_err;
  logic         r_sw;
  blob_result_t r_res;
  logic         w_last_pix, w_border, w_start_ok, w_timeout, w_cat_end;
  blob_raster_counter #(.IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW)) u_raster (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (r_state == STREAM),
    .i_clr      (r_state == ARM),
    .o_last_pix (w_last_pix),
    .o_border   (w_border)
  );
  assign w_start_ok = i_start & ((r_state == IDLE) | (r_state == HOLD));
  assign w_timeout  = (r_state == WAIT_RES) & ~i_blob_done & (r_wait == TO_LAST);
  assign w_cat_end  = r_wait == CAT_LAST;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = i_start ? ARM : IDLE;
      ARM:      w_next = STREAM;
      STREAM:   w_next = w_last_pix ? WAIT_RES : STREAM;
      WAIT_RES: w_next = i_blob_done ? (i_mode ? CAT : HOLD) : (w_timeout ? RELEASE : WAIT_RES);
      CAT:      w_next = w_cat_end ? HOLD : CAT;
      HOLD:     w_next = i_start ? RELEASE : HOLD;
      RELEASE:  w_next = (r_wait == 20'd1) ? ARM : RELEASE;
      default:  w_next = IDLE;
    endcase
  end
  // r_wait restarts on every state change and serves WAIT_RES, CAT and RELEASE
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_err   <= '0;
      r_sw    <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_next != r_state) ? '0 : (&r_wait ? r_wait : r_wait + 20'd1);
      if (w_start_ok) r_err <= '0;
      else begin
        if ((r_state == STREAM) && !i_pix_valid) r_err[ERR_UNDERRUN] <= 1'b1;
        if (w_timeout) r_err[ERR_TIMEOUT] <= 1'b1;
      end
      if (w_timeout) r_res <= '0;
      else begin
        if ((r_state == WAIT_RES) && i_blob_done) r_res.count <= i_blob_count;
        if ((r_state == CAT) && w_cat_end) begin
          r_res.bigger  <= i_blob_bigger;
          r_res.smaller <= i_blob_smaller;
        end
      end
      r_sw <= (r_state == CAT) | ((r_state == HOLD) & r_sw & i_mode);
    end
  assign o_pix_ready   = r_state == STREAM;
  assign o_blob_valid  = (r_state != IDLE) & (r_state != RELEASE);
  assign o_blob_seq    = o_pix_ready & i_pix_valid & (i_pix_luma > i_threshold) & ~(MASK_BORDER & w_border);
  assign o_blob_switch = (r_state == CAT) | ((r_state == HOLD) & r_sw);
  assign o_busy        = (r_state != IDLE) & (r_state != HOLD);
  assign o_done        = r_state == HOLD;
  assign o_err         = r_err;
  assign o_count       = r_res.count;
  assign o_bigger      = r_res.bigger;
  assign o_smaller     = r_res.smaller;
endmodule

// File: tb/tb_blob_scan_sequencer.sv
// tb_blob_scan_sequencer: small-frame bench with a behavioural blob counter and a per-pixel seq scoreboard
module tb_blob_scan_sequencer;
  localparam int COLS = 40, ROWS = 30, CATW = 64, TOUT = 3000;
  localparam int NPIX = COLS * ROWS, NBORD = 2 * COLS + 2 * (ROWS - 2), M_LAT = 5;
`ifdef SEQ_BORDER_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, i_start = 1'b0, i_mode = 1'b0;
  logic [7:0] thr = 8'd0, pix_luma = 8'd0, m_count = 8'd0, m_bigger = 8'd0, m_smaller = 8'd0;
  logic pix_valid = 1'b0, blob_done = 1'b0;
  logic o_pix_ready, o_blob_valid, o_blob_seq, o_blob_switch, o_busy, o_done;
  logic [7:0] o_count, o_bigger, o_smaller;
  logic [1:0] o_err;
  int total = 0, bad = 0;
  int pat = 0, ur_start = -1, ur_len = 0, m_cnt = 0;
  bit m_en = 1'b1, m_streamed = 1'b0, prev_ready = 1'b0;
  int s_col = 0, s_row = 0, f_cycles = 0, f_ones = 0, f_ur_zero = 0, f_border_zero = 0;
  bit sb_q[$];

  blob_scan_sequencer #(.IMG_COL(COLS), .IMG_ROW(ROWS), .CAT_WAIT(CATW), .TIMEOUT_CYC(TOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode), .i_threshold(thr),
    .i_pix_valid(pix_valid), .i_pix_luma(pix_luma), .o_pix_ready(o_pix_ready),
    .o_blob_valid(o_blob_valid), .o_blob_seq(o_blob_seq), .o_blob_switch(o_blob_switch),
    .i_blob_done(blob_done), .i_blob_count(m_count), .i_blob_bigger(m_bigger),
    .i_blob_smaller(m_smaller), .o_count(o_count), .o_bigger(o_bigger), .o_smaller(o_smaller),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] luma_of(int p, int c, int r);
    if (p == 0) return (r >= 10 && r <= 19 && c >= 10 && c <= 19) ? 8'd200 : 8'd0;
    if (p == 1) return 8'd128;
    return 8'd255;
  endfunction

  // counter model: done M_LAT cycles after the stream ends, held until o_blob_valid drops
  always @(negedge clk) begin
    if (o_blob_valid !== 1'b1) begin m_streamed = 0; m_cnt = 0; blob_done = 0; end
    else if (o_pix_ready) begin m_streamed = 1; m_cnt = 0; end
    else if (m_streamed && m_en) begin m_cnt++; if (m_cnt >= M_LAT) blob_done = 1; end
  end

  // pixel source pushes the expected seq bit, then checks it just before the accepting edge
  always @(negedge clk) begin
    int idx;
    bit v, bd, e;
    logic [7:0] l;
    if (o_pix_ready === 1'b1) begin
      if (!prev_ready) begin
        s_col = 0; s_row = 0; f_cycles = 0; f_ones = 0; f_ur_zero = 0; f_border_zero = 0;
        sb_q.delete();
      end
      idx = s_row * COLS + s_col;
      v = !(idx >= ur_start && idx < ur_start + ur_len);
      l = luma_of(pat, s_col, s_row);
      bd = (s_col == 0) || (s_col == COLS - 1) || (s_row == 0) || (s_row == ROWS - 1);
      pix_valid = v;
      pix_luma = v ? l : 8'hFF;
      sb_q.push_back(v && (l > thr) && !(MASK && bd));
      #2;
      e = sb_q.pop_front();
      total++;
      if (o_blob_seq !== e) begin
        bad++;
        $display("FAIL seq col=%0d row=%0d got=%b want=%b", s_col, s_row, o_blob_seq, e);
      end
      f_cycles++;
      if (o_blob_seq) f_ones++;
      if (!v && !o_blob_seq) f_ur_zero++;
      if (bd && !o_blob_seq) f_border_zero++;
      if (s_col == COLS - 1) begin s_col = 0; s_row++; end else s_col++;
      prev_ready = 1'b1;
    end else begin
      pix_valid = 1'b0;
      pix_luma = 8'd0;
      prev_ready = 1'b0;
    end
  end

  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (o_done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (o_done !== 1'b1) n = -1;
  endtask

  task automatic wait_ready(input logic lvl, input int budget, output int n);
    n = 0;
    while (o_pix_ready !== lvl && n < budget) begin @(negedge clk); n++; end
    if (o_pix_ready !== lvl) n = -1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_busy, o_done, o_pix_ready, o_blob_valid, o_blob_switch, o_blob_seq, o_err} !== 8'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {o_busy, o_done, o_pix_ready, o_blob_valid, o_blob_switch, o_blob_seq, o_err});
    end
    total++;
    if ({o_count, o_bigger, o_smaller} !== 24'd0) begin
      bad++; $display("FAIL reset_results got=%h want=0", {o_count, o_bigger, o_smaller});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_blob_valid !== 1'b0) begin
      bad++; $display("FAIL idle_hold busy=%b valid=%b want=0,0", o_busy, o_blob_valid);
    end
  endtask

  task automatic test_blob_frame();
    int n;
    pat = 0; thr = 8'd100; i_mode = 1'b0; m_count = 8'd1;
    pulse_start();
    total++;
    if ({o_blob_valid, o_pix_ready, o_busy} !== 3'b101) begin
      bad++; $display("FAIL arm_state got=%b want=101", {o_blob_valid, o_pix_ready, o_busy});
    end
    @(negedge clk);
    total++;
    if (o_pix_ready !== 1'b1) begin bad++; $display("FAIL arm_one_cycle ready=%b want=1", o_pix_ready); end
    wait_done(NPIX + 100, n);
    total++;
    if (n < 0) begin bad++; $display("FAIL t1_done_timeout got=%0d want>=0", n); end
    total++;
    if (f_cycles != NPIX) begin bad++; $display("FAIL t1_stream_len got=%0d want=%0d", f_cycles, NPIX); end
    total++;
    if (f_ones != 100) begin bad++; $display("FAIL t1_ones got=%0d want=100", f_ones); end
    total++;
    if (o_count !== 8'd1 || o_done !== 1'b1 || o_err !== 2'b00) begin
      bad++; $display("FAIL t1_result count=%0d done=%b err=%b want=1,1,00", o_count, o_done, o_err);
    end
    total++;
    if (o_blob_valid !== 1'b1 || o_blob_switch !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL t1_hold valid=%b switch=%b busy=%b want=1,0,0", o_blob_valid, o_blob_switch, o_busy);
    end
  endtask

  task automatic test_underrun();
    int n;
    pat = 0; thr = 8'd100; m_count = 8'd1;
    ur_start = 12 * COLS + 12; ur_len = 5;
    pulse_start();
    wait_done(NPIX + 100, n);
    ur_start = -1; ur_len = 0;
    total++;
    if (n < 0) begin bad++; $display("FAIL t3_done_timeout got=%0d want>=0", n); end
    total++;
    if (f_ur_zero != 5 || f_ones != 95) begin
      bad++; $display("FAIL t3_underrun zeros=%0d ones=%0d want=5,95", f_ur_zero, f_ones);
    end
    total++;
    if (f_cycles != NPIX) begin bad++; $display("FAIL t3_stream_len got=%0d want=%0d", f_cycles, NPIX); end
    total++;
    if (o_err !== 2'b01) begin bad++; $display("FAIL t3_err got=%b want=01", o_err); end
  endtask

  task automatic test_threshold_equal();
    int n;
    pat = 1; thr = 8'd128; m_count = 8'd0;
    pulse_start();
    total++;
    if (o_blob_valid !== 1'b0 || o_err !== 2'b00 || o_busy !== 1'b1) begin
      bad++; $display("FAIL release1 valid=%b err=%b busy=%b want=0,00,1", o_blob_valid, o_err, o_busy);
    end
    @(negedge clk);
    total++;
    if (o_blob_valid !== 1'b0) begin bad++; $display("FAIL release2 valid=%b want=0", o_blob_valid); end
    @(negedge clk);
    total++;
    if ({o_blob_valid, o_pix_ready} !== 2'b10) begin
      bad++; $display("FAIL rearm got=%b want=10", {o_blob_valid, o_pix_ready});
    end
    wait_done(NPIX + 100, n);
    total++;
    if (n < 0) begin bad++; $display("FAIL t2_done_timeout got=%0d want>=0", n); end
    total++;
    if (f_ones != 0 || o_count !== 8'd0) begin
      bad++; $display("FAIL t2_equal ones=%0d count=%0d want=0,0", f_ones, o_count);
    end
  endtask

  task automatic test_categorize();
    int n, sw;
    i_mode = 1'b1; m_count = 8'd2; m_bigger = 8'd3; m_smaller = 8'd4;
    pulse_start();
    n = 0; sw = 0;
    while (o_done !== 1'b1 && n < NPIX + 500) begin
      if (o_blob_switch === 1'b1) sw++;
      @(negedge clk); n++;
    end
    total++;
    if (sw != CATW) begin bad++; $display("FAIL t5_switch_cycles got=%0d want=%0d", sw, CATW); end
    total++;
    if (o_bigger !== 8'd3 || o_smaller !== 8'd4 || o_count !== 8'd2) begin
      bad++; $display("FAIL t5_results got=%0d,%0d,%0d want=2,3,4", o_count, o_bigger, o_smaller);
    end
    total++;
    if (o_blob_switch !== 1'b1 || o_done !== 1'b1) begin
      bad++; $display("FAIL t5_hold_switch switch=%b done=%b want=1,1", o_blob_switch, o_done);
    end
    i_mode = 1'b0;
    @(negedge clk);
    total++;
    if (o_blob_switch !== 1'b0 || o_done !== 1'b1 || o_bigger !== 8'd3) begin
      bad++; $display("FAIL t5_mode_drop switch=%b done=%b bigger=%0d want=0,1,3", o_blob_switch, o_done, o_bigger);
    end
  endtask

  task automatic test_timeout();
    int n, k;
    m_en = 1'b0;
    pulse_start();
    wait_ready(1'b1, 20, n);
    wait_ready(1'b0, NPIX + 20, n);
    total++;
    if (n < 0) begin bad++; $display("FAIL t4_stream_end got=%0d want>=0", n); end
    k = 0;
    while (o_err[1] !== 1'b1 && k < TOUT + 2000) begin k++; @(negedge clk); end
    total++;
    if (k != TOUT) begin bad++; $display("FAIL t4_wait_len got=%0d want=%0d", k, TOUT); end
    total++;
    if (o_err !== 2'b10 || {o_count, o_bigger, o_smaller} !== 24'd0) begin
      bad++; $display("FAIL t4_outputs err=%b res=%h want=10,0", o_err, {o_count, o_bigger, o_smaller});
    end
    total++;
    if (o_blob_valid !== 1'b0) begin bad++; $display("FAIL t4_release1 valid=%b want=0", o_blob_valid); end
    @(negedge clk);
    total++;
    if (o_blob_valid !== 1'b0) begin bad++; $display("FAIL t4_release2 valid=%b want=0", o_blob_valid); end
    @(negedge clk);
    total++;
    if ({o_blob_valid, o_pix_ready, o_err} !== 4'b1010) begin
      bad++; $display("FAIL t4_rearm got=%b want=1010", {o_blob_valid, o_pix_ready, o_err});
    end
    m_en = 1'b1;
  endtask

  task automatic test_reset_and_border();
    int n;
    n = 0;
    do begin @(negedge clk); #3; n++; end while (f_cycles != 1000 && n < NPIX + 50);
    total++;
    if (f_cycles != 1000) begin bad++; $display("FAIL t6_reach_1000 got=%0d want=1000", f_cycles); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_blob_valid, o_pix_ready, o_busy, o_err} !== 5'd0) begin
      bad++; $display("FAIL t6_async_reset got=%b want=0", {o_blob_valid, o_pix_ready, o_busy, o_err});
    end
    @(negedge clk); rst_n = 1'b1;
    pat = 2; thr = 8'd100; m_count = 8'd7;
    pulse_start();
    wait_ready(1'b1, 10, n);
    repeat (100) @(negedge clk);
    pulse_start();
    total++;
    if (o_pix_ready !== 1'b1 || o_busy !== 1'b1) begin
      bad++; $display("FAIL t6_start_ignored ready=%b busy=%b want=1,1", o_pix_ready, o_busy);
    end
    wait_done(NPIX + 100, n);
    total++;
    if (n < 0 || f_cycles != NPIX) begin
      bad++; $display("FAIL t6_stream_len got=%0d want=%0d", f_cycles, NPIX);
    end
    total++;
    if (f_border_zero != (MASK ? NBORD : 0) || f_ones != NPIX - (MASK ? NBORD : 0)) begin
      bad++; $display("FAIL t6_border zeros=%0d ones=%0d want=%0d,%0d", f_border_zero, f_ones, MASK ? NBORD : 0, NPIX - (MASK ? NBORD : 0));
    end
    repeat (3) @(negedge clk);
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_count !== 8'd7) begin
      bad++; $display("FAIL t6_hold done=%b busy=%b count=%0d want=1,0,7", o_done, o_busy, o_count);
    end
  endtask

  initial begin
    test_reset();
    test_blob_frame();
    test_underrun();
    test_threshold_equal();
    test_categorize();
    test_timeout();
    test_reset_and_border();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
